// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: bundle of the MEM-stage request channel, completion channel,
// memory data port and watchdog error for the load/store initiator.
//   master : the initiator (drives req_ready, rsp_*, dmem_* requests, err)
//   slave  : the environment (pipeline + memory responder)
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_store;
  logic        rsp_fault;
  logic [31:0] rsp_addr;
  logic [3:0]  rsp_rmask;
  logic [3:0]  rsp_wmask;
  logic [31:0] rsp_wdata;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic        err;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  dmem_rdata, dmem_resp,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_rd, rsp_store, rsp_fault,
    output rsp_addr, rsp_rmask, rsp_wmask, rsp_wdata,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output err
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output dmem_rdata, dmem_resp,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_rd, rsp_store, rsp_fault,
    input  rsp_addr, rsp_rmask, rsp_wmask, rsp_wdata,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  err
  );
endinterface

// File: rtl/dmem_lsu_initiator.sv
// dmem_lsu_initiator: CPU-side initiator of the pipelined 32-bit masked data
// port. Accepts one load/store per cycle, drives word-aligned address, byte
// masks and lane-aligned store data combinationally in the accept cycle,
// waits for dmem_resp, then returns an aligned, extended load result.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - dmem_lsu_if.master (request, response, memory port, err)
// Parameter:
//   WATCHDOG - WAIT cycles without dmem_resp before sticky err is raised
module dmem_lsu_initiator #(
  parameter int WATCHDOG = 1024
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [1:0]  w_off;
  logic        w_fault;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata_al;
  logic        w_ready;
  logic        w_accept;
  logic        w_issue;
  logic        w_resp_done;
  logic [31:0] w_shift;
  logic [31:0] w_load;

  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_store;
  logic [4:0]  r_rd;
  logic [3:0]  r_rmask;
  logic [3:0]  r_wmask;
  logic [31:0] r_wdata;
  logic [31:0] r_wd_cnt;

  assign w_off       = bus.req_addr[1:0];
  assign w_wdata_al  = bus.req_wdata << {w_off, 3'b000};
  assign w_resp_done = (r_state == ST_WAIT) && bus.dmem_resp;

  // Width decode: byte-lane mask and alignment/illegal-code fault detection
  always_comb begin
    w_fault = 1'b0;
    w_mask  = 4'b0000;
    case (bus.req_funct3)
      3'b000, 3'b100: w_mask = 4'b0001 << w_off;
      3'b001, 3'b101: begin
        w_mask  = 4'b0011 << w_off;
        w_fault = bus.req_addr[0];
      end
      3'b010: begin
        w_mask  = 4'b1111;
        w_fault = (w_off != 2'b00);
      end
      default: w_fault = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; a faulting accept always detours through FAULT
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = w_fault ? ST_FAULT : ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.dmem_resp) begin
          if (w_accept) begin
            w_next_state = w_fault ? ST_FAULT : ST_WAIT;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_FAULT: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: ready and the memory request, combinational from req_* so
  // the responder can sample a new op in the same cycle it completes one
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE:  w_ready = !rst;
      ST_WAIT:  w_ready = !rst && bus.dmem_resp;
      ST_FAULT: w_ready = 1'b0;
      default:  w_ready = 1'b0;
    endcase
    w_accept = bus.req_valid && w_ready;
    w_issue  = w_accept && !w_fault;

    bus.req_ready  = w_ready;
    bus.dmem_addr  = 32'h0000_0000;
    bus.dmem_rmask = 4'b0000;
    bus.dmem_wmask = 4'b0000;
    bus.dmem_wdata = 32'h0000_0000;
    if (w_issue) begin
      bus.dmem_addr  = {bus.req_addr[31:2], 2'b00};
      bus.dmem_wdata = w_wdata_al;
      if (bus.req_store) begin
        bus.dmem_wmask = w_mask;
      end else begin
        bus.dmem_rmask = w_mask;
      end
    end else begin
      bus.dmem_addr  = 32'h0000_0000;
      bus.dmem_wdata = 32'h0000_0000;
    end
  end

  // Capture the accepted request for response formatting and retirement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= 32'h0000_0000;
      r_funct3 <= 3'b000;
      r_store  <= 1'b0;
      r_rd     <= 5'd0;
      r_rmask  <= 4'b0000;
      r_wmask  <= 4'b0000;
      r_wdata  <= 32'h0000_0000;
    end else if (w_accept) begin
      r_addr   <= bus.req_addr;
      r_funct3 <= bus.req_funct3;
      r_store  <= bus.req_store;
      r_rd     <= bus.req_rd;
      r_rmask  <= (w_issue && !bus.req_store) ? w_mask : 4'b0000;
      r_wmask  <= (w_issue &&  bus.req_store) ? w_mask : 4'b0000;
      r_wdata  <= w_wdata_al;
    end
  end

  // Load extraction: move the addressed byte/half to bit 0, then extend
  always_comb begin
    w_shift = bus.dmem_rdata >> {r_addr[1:0], 3'b000};
    w_load  = 32'h0000_0000;
    case (r_funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load = {24'h00_0000, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_load = {16'h0000, w_shift[15:0]};
      3'b010:  w_load = bus.dmem_rdata;
      default: w_load = 32'h0000_0000;
    endcase
  end

  // Registered completion: memory-op result or one-cycle fault report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0000_0000;
      bus.rsp_rd    <= 5'd0;
      bus.rsp_store <= 1'b0;
      bus.rsp_fault <= 1'b0;
      bus.rsp_addr  <= 32'h0000_0000;
      bus.rsp_rmask <= 4'b0000;
      bus.rsp_wmask <= 4'b0000;
      bus.rsp_wdata <= 32'h0000_0000;
    end else if (w_resp_done || (r_state == ST_FAULT)) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_rdata <= (w_resp_done && !r_store) ? w_load : 32'h0000_0000;
      bus.rsp_rd    <= r_rd;
      bus.rsp_store <= r_store;
      bus.rsp_fault <= (r_state == ST_FAULT);
      bus.rsp_addr  <= r_addr;
      bus.rsp_rmask <= r_rmask;
      bus.rsp_wmask <= r_wmask;
      bus.rsp_wdata <= r_wdata;
    end else begin
      bus.rsp_valid <= 1'b0;
    end
  end

  // Watchdog: restart on every issue, count stalled WAIT cycles, sticky err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= 32'd0;
      bus.err  <= 1'b0;
    end else if (w_issue) begin
      r_wd_cnt <= 32'd0;
    end else if ((r_state == ST_WAIT) && !bus.dmem_resp) begin
      if (r_wd_cnt != 32'(WATCHDOG)) begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
      end
      if ((r_wd_cnt + 32'd1) >= 32'(WATCHDOG)) begin
        bus.err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_initiator.sv
// Directed self-checking bench for dmem_lsu_initiator (WATCHDOG = 8).
module tb_dmem_lsu_initiator;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dmem_lsu_if bus ();

  dmem_lsu_initiator #(.WATCHDOG(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid  = v;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    #1;
  endtask

  task automatic set_resp(input logic r, input logic [31:0] d);
    bus.dmem_resp  = r;
    bus.dmem_rdata = d;
    #1;
  endtask

  // From the accept cycle: zero-wait response, ends in the rsp_valid cycle
  task automatic do_resp(input logic [31:0] d);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    set_resp(1'b1, d);
    tick();
    set_resp(1'b0, 32'h0);
  endtask

  logic [31:0] lw_data [3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    lw_data[0] = 32'h1111_1111;
    lw_data[1] = 32'h2222_2222;
    lw_data[2] = 32'h3333_3333;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    set_resp(1'b0, 32'h0);

    // Reset state
    tick();
    tick();
    chk("rst_ready", bus.req_ready, 32'd0);
    chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
    chk("rst_err", bus.err, 32'd0);
    chk("rst_rmask", bus.dmem_rmask, 32'd0);
    chk("rst_wmask", bus.dmem_wmask, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", bus.req_ready, 32'd1);

    // LW 0x1000, zero-wait
    set_req(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 5'd5);
    chk("lw_addr", bus.dmem_addr, 32'h0000_1000);
    chk("lw_rmask", bus.dmem_rmask, 32'hF);
    chk("lw_wmask", bus.dmem_wmask, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    set_resp(1'b1, 32'hDEAD_BEEF);
    chk("lw_ready_resp", bus.req_ready, 32'd1);
    chk("lw_no_early_rsp", bus.rsp_valid, 32'd0);
    tick();
    set_resp(1'b0, 32'h0);
    chk("lw_rsp_valid", bus.rsp_valid, 32'd1);
    chk("lw_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("lw_rsp_rd", bus.rsp_rd, 32'd5);
    chk("lw_rsp_fault", bus.rsp_fault, 32'd0);
    chk("lw_rsp_rmask", bus.rsp_rmask, 32'hF);
    tick();
    chk("lw_rsp_pulse", bus.rsp_valid, 32'd0);

    // LB / LBU 0x1003, LH / LHU 0x1002
    set_req(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd6);
    chk("lb_rmask", bus.dmem_rmask, 32'h8);
    chk("lb_addr", bus.dmem_addr, 32'h0000_1000);
    do_resp(32'h8012_3456);
    chk("lb_rdata", bus.rsp_rdata, 32'hFFFF_FF80);
    set_req(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd6);
    do_resp(32'h8012_3456);
    chk("lbu_rdata", bus.rsp_rdata, 32'h0000_0080);
    set_req(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 5'd8);
    chk("lh_rmask", bus.dmem_rmask, 32'hC);
    do_resp(32'h8001_0000);
    chk("lh_rdata", bus.rsp_rdata, 32'hFFFF_8001);
    set_req(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 5'd8);
    do_resp(32'h8001_0000);
    chk("lhu_rdata", bus.rsp_rdata, 32'h0000_8001);

    // SH 0x2002
    set_req(1'b1, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd0);
    chk("sh_addr", bus.dmem_addr, 32'h0000_2000);
    chk("sh_wmask", bus.dmem_wmask, 32'hC);
    chk("sh_rmask", bus.dmem_rmask, 32'h0);
    chk("sh_wdata", bus.dmem_wdata, 32'hABCD_0000);
    do_resp(32'hFFFF_FFFF);
    chk("sh_rsp_valid", bus.rsp_valid, 32'd1);
    chk("sh_rsp_store", bus.rsp_store, 32'd1);
    chk("sh_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("sh_rsp_wmask", bus.rsp_wmask, 32'hC);
    chk("sh_rsp_wdata", bus.rsp_wdata, 32'hABCD_0000);

    // Illegal funct3 from IDLE
    set_req(1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0, 5'd4);
    chk("ill_ready", bus.req_ready, 32'd1);
    chk("ill_rmask", bus.dmem_rmask, 32'h0);
    chk("ill_addr", bus.dmem_addr, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    chk("ill_fault_ready", bus.req_ready, 32'd0);
    chk("ill_no_early_rsp", bus.rsp_valid, 32'd0);
    tick();
    chk("ill_rsp_valid", bus.rsp_valid, 32'd1);
    chk("ill_rsp_fault", bus.rsp_fault, 32'd1);
    chk("ill_rsp_rd", bus.rsp_rd, 32'd4);
    chk("ill_rsp_rdata", bus.rsp_rdata, 32'h0);

    // Three LWs held valid, responder answers 5 cycles after each accept
    tick();
    set_req(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd1);
    chk("bb_ready0", bus.req_ready, 32'd1);
    chk("bb_addr0", bus.dmem_addr, 32'h0000_0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      set_resp(1'b0, 32'h0);
      if (k < 2) set_req(1'b1, 1'b0, 3'b010, 32'h0000_0100 + 32'(4 * (k + 1)), 32'h0, 5'(k + 2));
      else       set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
      if (k > 0) begin
        chk("bb_rsp_valid", bus.rsp_valid, 32'd1);
        chk("bb_rsp_rd", bus.rsp_rd, 32'(k));
        chk("bb_rsp_rdata", bus.rsp_rdata, lw_data[k - 1]);
      end
      for (int s = 0; s < 4; s++) begin
        if (s > 0) begin
          tick();
          chk("bb_stall_rsp", bus.rsp_valid, 32'd0);
        end
        chk("bb_stall_ready", bus.req_ready, 32'd0);
        chk("bb_stall_rmask", bus.dmem_rmask, 32'h0);
      end
      tick();
      set_resp(1'b1, lw_data[k]);
      chk("bb_resp_ready", bus.req_ready, 32'd1);
      if (k < 2) begin
        chk("bb_next_addr", bus.dmem_addr, 32'h0000_0100 + 32'(4 * (k + 1)));
        chk("bb_next_rmask", bus.dmem_rmask, 32'hF);
      end
    end
    tick();
    set_resp(1'b0, 32'h0);
    chk("bb_last_valid", bus.rsp_valid, 32'd1);
    chk("bb_last_rd", bus.rsp_rd, 32'd3);
    chk("bb_last_rdata", bus.rsp_rdata, 32'h3333_3333);

    // Misaligned LW accepted in a resp cycle
    tick();
    set_req(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd7);
    tick();
    set_resp(1'b1, 32'hCAFE_F00D);
    set_req(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 5'd9);
    chk("mis_ready", bus.req_ready, 32'd1);
    chk("mis_rmask", bus.dmem_rmask, 32'h0);
    chk("mis_wmask", bus.dmem_wmask, 32'h0);
    chk("mis_addr", bus.dmem_addr, 32'h0);
    tick();
    set_resp(1'b0, 32'h0);
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    chk("mis_t1_ready", bus.req_ready, 32'd0);
    chk("mis_t1_valid", bus.rsp_valid, 32'd1);
    chk("mis_t1_rd", bus.rsp_rd, 32'd7);
    chk("mis_t1_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    chk("mis_t1_fault", bus.rsp_fault, 32'd0);
    tick();
    chk("mis_t2_ready", bus.req_ready, 32'd1);
    chk("mis_t2_valid", bus.rsp_valid, 32'd1);
    chk("mis_t2_fault", bus.rsp_fault, 32'd1);
    chk("mis_t2_rd", bus.rsp_rd, 32'd9);
    chk("mis_t2_rdata", bus.rsp_rdata, 32'h0);
    tick();
    chk("mis_t3_valid", bus.rsp_valid, 32'd0);

    // Watchdog: responder never answers
    chk("wd_err_pre", bus.err, 32'd0);
    set_req(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd2);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
      chk("wd_err_low", bus.err, 32'd0);
    end
    tick();
    chk("wd_err_rise", bus.err, 32'd1);
    tick();
    tick();
    chk("wd_err_sticky", bus.err, 32'd1);
    chk("wd_still_wait", bus.req_ready, 32'd0);

    // Asynchronous reset mid-WAIT, then a stray late response
    rst = 1'b1;
    #1;
    chk("arst_err", bus.err, 32'd0);
    chk("arst_ready", bus.req_ready, 32'd0);
    chk("arst_valid", bus.rsp_valid, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_ready_after", bus.req_ready, 32'd1);
    set_resp(1'b1, 32'h5555_AAAA);
    tick();
    set_resp(1'b0, 32'h0);
    chk("stray_no_rsp", bus.rsp_valid, 32'd0);
    chk("stray_err", bus.err, 32'd0);
    chk("stray_ready", bus.req_ready, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
